// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID decode into the ID/EX control register, load-use stall,
// branch flush, divide hold FSM and illegal-opcode bubbling. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit #(
    parameter int unsigned OPCODE_W   = 3,
    parameter int unsigned FUNCT_W    = 2,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [FUNCT_W-1:0]  id_funct,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                ex_branch_taken,
    output logic                ex_valid,
    output logic [1:0]          ex_alu_op,
    output logic                ex_mem_to_reg,
    output logic                ex_byte_en,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_src,
    output logic                ex_alu_src,
    output logic                ex_reg_write,
    output logic                ex_cmp,
    output logic                ex_blt,
    output logic                ex_bge,
    output logic                ex_jmp,
    output logic [REG_W-1:0]    ex_rd,
    output logic                stall_if,
    output logic                flush_ifid,
    output logic                ex_hold,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt,
`endif
    output logic                illegal_instr
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [0:0] {StRun, StDivWait} state_e;

    state_e           state;
    logic [CNT_W-1:0] div_cnt;
    logic             ex_div;
    logic [12:0]      ex_ctrl;

    logic [1:0]  fn;
    logic        d_legal, d_use_rs1, d_use_rs2, d_div;
    logic [1:0]  d_alu_op;
    logic        d_mem_to_reg, d_byte_en, d_mem_read, d_mem_write, d_reg_src, d_alu_src;
    logic        d_reg_write, d_cmp, d_blt, d_bge, d_jmp;
    logic [12:0] d_ctrl;
    logic        load_use, div_wait, id_load;

    assign fn = id_funct[1:0];

    always_comb begin
        d_legal      = 1'b0;
        d_use_rs1    = 1'b0;
        d_use_rs2    = 1'b0;
        d_div        = 1'b0;
        d_alu_op     = 2'b00;
        d_mem_to_reg = 1'b0;
        d_byte_en    = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_reg_src    = 1'b0;
        d_alu_src    = 1'b0;
        d_reg_write  = 1'b0;
        d_cmp        = 1'b0;
        d_blt        = 1'b0;
        d_bge        = 1'b0;
        d_jmp        = 1'b0;
        case (id_opcode)
            OPCODE_W'(0): begin
                {d_legal, d_use_rs1, d_use_rs2, d_reg_write} = 4'b1111;
                d_alu_op = 2'b10;
                d_div    = (fn == 2'b11);
            end
            OPCODE_W'(1): begin
                {d_legal, d_use_rs1, d_use_rs2, d_reg_write} = 4'b1111;
                d_alu_op = 2'b10;
                d_cmp    = (fn == 2'b10);
            end
            OPCODE_W'(2): begin
                {d_legal, d_use_rs1, d_alu_src, d_reg_write} = 4'b1111;
            end
            OPCODE_W'(3): begin
                {d_legal, d_use_rs1, d_alu_src, d_reg_write} = 4'b1111;
                {d_mem_read, d_mem_to_reg} = 2'b11;
                d_byte_en = (fn == 2'b00);
            end
            OPCODE_W'(4): begin
                {d_legal, d_use_rs1, d_use_rs2, d_alu_src, d_mem_write} = 5'b11111;
                d_byte_en = (fn == 2'b00);
            end
            OPCODE_W'(5): begin
                {d_legal, d_alu_src, d_reg_src} = 3'b111;
                d_alu_op  = 2'b01;
                d_blt     = (fn == 2'b00);
                d_bge     = (fn == 2'b01);
                d_jmp     = (fn == 2'b10);
                d_use_rs1 = (fn != 2'b10);
                d_use_rs2 = (fn != 2'b10);
            end
            default: ;
        endcase
    end

    assign d_ctrl = {d_alu_op, d_mem_to_reg, d_byte_en, d_mem_read, d_mem_write, d_reg_src,
                     d_alu_src, d_reg_write, d_cmp, d_blt, d_bge, d_jmp};

    assign {ex_alu_op, ex_mem_to_reg, ex_byte_en, ex_mem_read, ex_mem_write, ex_reg_src,
            ex_alu_src, ex_reg_write, ex_cmp, ex_blt, ex_bge, ex_jmp} = ex_ctrl;

    // Illegal ops have no used sources, so they never trigger a load-use stall.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                      ((d_use_rs1 && (id_rs1 == ex_rd)) || (d_use_rs2 && (id_rs2 == ex_rd)));
    assign div_wait = (state == StDivWait);

    assign flush_ifid = !rst && ex_branch_taken;
    assign ex_hold    = !rst && div_wait;
    assign stall_if   = !rst && !ex_branch_taken && (div_wait || load_use);
    assign id_load    = !ex_branch_taken && !div_wait && !load_use && id_valid && d_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
            ex_rd         <= '0;
            ex_div        <= 1'b0;
            illegal_instr <= 1'b0;
            state         <= StRun;
            div_cnt       <= '0;
        end else begin
            illegal_instr <= id_valid && !d_legal && !ex_branch_taken && !stall_if;
            // A flush always bubbles ID/EX, even while the divider holds.
            if (ex_branch_taken || !div_wait) begin
                ex_valid <= id_load;
                ex_ctrl  <= id_load ? d_ctrl : '0;
                ex_rd    <= id_load ? id_rd : '0;
                ex_div   <= id_load && d_div;
            end
            unique case (state)
                StRun: begin
                    if (ex_valid && ex_div && (DIV_CYCLES > 1)) begin
                        state   <= StDivWait;
                        div_cnt <= CNT_W'(DIV_CYCLES - 1);
                    end
                end
                StDivWait: begin
                    if (div_cnt == CNT_W'(1)) begin
                        state   <= StRun;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt - CNT_W'(1);
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_if};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, flush_ifid};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural pipeline model.
module tb_pipe_ctrl_unit;

    localparam int unsigned DIVC = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] alu_op;
        logic       mem_to_reg, byte_en, mem_read, mem_write, reg_src, alu_src, reg_write;
        logic       cmp, blt, bge, jmp;
        logic [3:0] rd;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_opcode = '0;
    logic [1:0] id_funct = '0;
    logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       br = 1'b0;

    logic       ex_valid, ex_mem_to_reg, ex_byte_en, ex_mem_read, ex_mem_write, ex_reg_src;
    logic       ex_alu_src, ex_reg_write, ex_cmp, ex_blt, ex_bge, ex_jmp;
    logic [1:0] ex_alu_op;
    logic [3:0] ex_rd;
    logic       stall_if, flush_ifid, ex_hold, illegal_instr;

    logic       d1_valid, d1_m2r, d1_be, d1_mr, d1_mw, d1_rsrc, d1_asrc, d1_rw;
    logic       d1_cmp, d1_blt, d1_bge, d1_jmp, d1_stall, d1_flush, d1_hold, d1_ill;
    logic [1:0] d1_alu_op;
    logic [3:0] d1_rd;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, d1_ps, d1_pf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.DIV_CYCLES(DIVC)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(br),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_byte_en(ex_byte_en), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_src(ex_reg_src), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_cmp(ex_cmp), .ex_blt(ex_blt), .ex_bge(ex_bge), .ex_jmp(ex_jmp), .ex_rd(ex_rd),
        .stall_if(stall_if), .flush_ifid(flush_ifid), .ex_hold(ex_hold),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .illegal_instr(illegal_instr)
    );

    // Single-cycle divide variant: must never hold.
    pipe_ctrl_unit #(.DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(br),
        .ex_valid(d1_valid), .ex_alu_op(d1_alu_op), .ex_mem_to_reg(d1_m2r),
        .ex_byte_en(d1_be), .ex_mem_read(d1_mr), .ex_mem_write(d1_mw),
        .ex_reg_src(d1_rsrc), .ex_alu_src(d1_asrc), .ex_reg_write(d1_rw),
        .ex_cmp(d1_cmp), .ex_blt(d1_blt), .ex_bge(d1_bge), .ex_jmp(d1_jmp), .ex_rd(d1_rd),
        .stall_if(d1_stall), .flush_ifid(d1_flush), .ex_hold(d1_hold),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt(d1_ps), .perf_flush_cnt(d1_pf),
`endif
        .illegal_instr(d1_ill)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    function automatic logic uses_rs1(input logic [2:0] op, input logic [1:0] fn);
        return is_legal(op) && !(op == 3'd5 && fn == 2'd2);
    endfunction

    function automatic logic uses_rs2(input logic [2:0] op, input logic [1:0] fn);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5 && fn != 2'd2);
    endfunction

    function automatic bundle_t decode(input logic [2:0] op, input logic [1:0] fn,
                                       input logic [3:0] rd);
        bundle_t b = '0;
        b.valid = 1'b1;
        b.rd    = rd;
        case (op)
            3'd0: begin b.alu_op = 2'b10; b.reg_write = 1; end
            3'd1: begin b.alu_op = 2'b10; b.reg_write = 1; b.cmp = (fn == 2'd2); end
            3'd2: begin b.alu_src = 1; b.reg_write = 1; end
            3'd3: begin
                b.alu_src = 1; b.mem_read = 1; b.mem_to_reg = 1; b.reg_write = 1;
                b.byte_en = (fn == 2'd0);
            end
            3'd4: begin b.alu_src = 1; b.mem_write = 1; b.byte_en = (fn == 2'd0); end
            3'd5: begin
                b.alu_op = 2'b01; b.alu_src = 1; b.reg_src = 1;
                b.blt = (fn == 2'd0); b.bge = (fn == 2'd1); b.jmp = (fn == 2'd2);
            end
            default: b = '0;
        endcase
        return b;
    endfunction

    // Model state: what ID/EX holds, remaining divide-wait cycles, pending illegal pulse.
    bundle_t m_ex = '0;
    logic    m_div = 1'b0;
    logic    m_ill = 1'b0;
    int      m_wait = 0;
    int unsigned m_ps = 0, m_pf = 0;
    logic    armed = 1'b0;
    int      d1_hold_cnt = 0;
    bundle_t dut_b;
    logic    e_lu, e_stall, e_flush, e_hold;

    always @(negedge clk) begin
        dut_b = {ex_valid, ex_alu_op, ex_mem_to_reg, ex_byte_en, ex_mem_read, ex_mem_write,
                 ex_reg_src, ex_alu_src, ex_reg_write, ex_cmp, ex_blt, ex_bge, ex_jmp, ex_rd};
        e_lu = m_ex.valid && m_ex.mem_read && (m_ex.rd != 0) && id_valid &&
               ((uses_rs1(id_opcode, id_funct) && id_rs1 == m_ex.rd) ||
                (uses_rs2(id_opcode, id_funct) && id_rs2 == m_ex.rd));
        e_flush = !rst && br;
        e_hold  = !rst && (m_wait > 0);
        e_stall = !rst && !br && ((m_wait > 0) || e_lu);
        if (armed) begin
            chk("ex_bundle", dut_b, m_ex);
            chk("illegal_instr", illegal_instr, m_ill);
            chk("stall_if", stall_if, e_stall);
            chk("flush_ifid", flush_ifid, e_flush);
            chk("ex_hold", ex_hold, e_hold);
`ifdef PIPE_CTRL_PERF_EN
            chk("perf_stall_cnt", perf_stall_cnt, m_ps);
            chk("perf_flush_cnt", perf_flush_cnt, m_pf);
`endif
        end
        if (d1_hold) d1_hold_cnt++;
        if (rst) begin
            m_ex = '0; m_div = 0; m_ill = 0; m_wait = 0; m_ps = 0; m_pf = 0; armed = 1;
        end else begin
            m_ps  = m_ps + (e_stall ? 1 : 0);
            m_pf  = m_pf + (e_flush ? 1 : 0);
            m_ill = id_valid && !is_legal(id_opcode) && !br && !e_stall;
            if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else if (m_ex.valid && m_div && DIVC > 1) begin
                m_wait = DIVC - 1;
            end
            if (br || (!e_hold && (e_lu || !id_valid || !is_legal(id_opcode)))) begin
                m_ex = '0; m_div = 0;
            end else if (!e_hold) begin
                m_ex  = decode(id_opcode, id_funct, id_rd);
                m_div = (id_opcode == 3'd0) && (id_funct == 2'd3);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] op, input logic [1:0] fn,
                       input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                       input logic b);
        id_valid = v; id_opcode = op; id_funct = fn;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; br = b;
        #1;
    endtask

    int hc, d1c;

    initial begin
        // Reset with a load waiting in ID.
        rst = 1;
        drv(1, 3'd3, 2'd1, 4'd1, 4'd0, 4'd5, 0);
        cyc();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_illegal", illegal_instr, 0);
        cyc();
        chk("rst_ex_mem_read", ex_mem_read, 0);
        rst = 0;
        cyc();
        chk("post_rst_load", {ex_mem_read, ex_mem_to_reg, ex_alu_src}, 3'b111);

        // Load-use: lw rd=5 in EX, addp rs1=5 in ID.
        drv(1, 3'd0, 2'd0, 4'd5, 4'd0, 4'd6, 0);
        chk("lu_stall", stall_if, 1);
        cyc();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_no_restall", stall_if, 0);
        cyc();
        chk("lu_addp_ex", {ex_valid, ex_reg_write, ex_rd}, {2'b11, 4'd6});

        drv(1, 3'd3, 2'd0, 4'd1, 4'd0, 4'd0, 0);
        cyc();
        drv(1, 3'd0, 2'd0, 4'd0, 4'd0, 4'd6, 0);
        chk("lu_rd0_nostall", stall_if, 0);
        cyc();

        // Branch beats load-use.
        drv(1, 3'd3, 2'd0, 4'd1, 4'd0, 4'd7, 0);
        cyc();
        drv(1, 3'd0, 2'd0, 4'd7, 4'd0, 4'd6, 1);
        chk("br_flush_stall", {flush_ifid, stall_if}, 2'b10);
        cyc();
        drv(0, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 0);
        chk("br_bubble", ex_valid, 0);

        // Divide hold.
        drv(1, 3'd0, 2'd3, 4'd1, 4'd1, 4'd2, 0);
        cyc();
        drv(1, 3'd0, 2'd0, 4'd1, 4'd1, 4'd3, 0);
        chk("div_first_ex_nohold", ex_hold, 0);
        hc = 0; d1c = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (ex_hold && stall_if) hc++;
            if (d1_hold || d1_stall) d1c++;
        end
        chk("div_hold_cycles", hc, DIVC - 1);
        chk("div1_no_hold", d1c, 0);

        // Illegal opcode.
        drv(1, 3'd6, 2'd0, 4'd0, 4'd0, 4'd1, 0);
        cyc();
        chk("ill_bubble_pulse", {ex_valid, illegal_instr}, 2'b01);
        drv(0, 3'd0, 2'd0, 4'd0, 4'd0, 4'd0, 0);
        cyc();
        chk("ill_pulse_end", illegal_instr, 0);

        // Branch decode.
        drv(1, 3'd5, 2'd3, 4'd1, 4'd2, 4'd0, 0);
        cyc();
        chk("br_f11", {ex_valid, ex_alu_op, ex_blt, ex_bge, ex_jmp}, 6'b101000);
        drv(1, 3'd3, 2'd0, 4'd1, 4'd0, 4'd3, 0);
        cyc();
        drv(1, 3'd5, 2'd2, 4'd3, 4'd3, 4'd0, 0);
        chk("jmp_nostall", stall_if, 0);
        cyc();
        chk("jmp_flag", {ex_valid, ex_jmp}, 2'b11);

        // Reset in the second divide-wait cycle.
        drv(1, 3'd0, 2'd3, 4'd1, 4'd1, 4'd2, 0);
        cyc();
        drv(1, 3'd0, 2'd0, 4'd1, 4'd1, 4'd3, 0);
        cyc();
        cyc();
        chk("div_wait2_hold", ex_hold, 1);
        rst = 1;
        #1;
        chk("rst_gates_hold", {ex_hold, stall_if}, 2'b00);
        cyc();
        rst = 0;
        #1;
        chk("rst_abort_div", {ex_hold, ex_valid}, 2'b00);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_perf_clear", {perf_stall_cnt, perf_flush_cnt}, 64'd0);
`endif

        // Randomized traffic, checked by the per-cycle model.
        repeat (3000) begin
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            drv(($urandom_range(0, 99) < 85), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end
        cyc();
        chk("div1_never_holds", d1_hold_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
